// File: rtl/vscale_fetch_unit.sv
// Instruction-fetch front end: issues imem requests with one fetch outstanding,
// drops responses overtaken by redirects and hands PC_IF/inst_IF to decode.
module vscale_fetch_unit #(
  parameter logic [31:0] START_ADDR = 32'h0000_0200
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] PC_PIF,
  input  logic        redirect,
  input  logic        stall_IF,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        imem_badmem_e,
  output logic [31:0] PC_IF,
  output logic [31:0] inst_IF,
  output logic        inst_valid_IF,
  output logic        fetch_fault
);

  typedef enum logic [1:0] {
    S_ISSUE = 2'd0,
    S_WAIT  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  state_t      state_q, state_d;
  logic [31:0] pc_if_q, pc_if_d;
  logic [31:0] inst_if_q, inst_if_d;
  logic        inst_valid_q, inst_valid_d;
  logic        fetch_fault_q, fetch_fault_d;
  logic        pend_redir_q, pend_redir_d;
  logic [31:0] redir_pc_q, redir_pc_d;
  logic [31:0] req_pc_q, req_pc_d;

  logic        req_fire;
  logic        resp_accept;

  assign req_fire    = imem_req_valid & imem_req_ready;
  assign resp_accept = (state_q == S_WAIT) & imem_resp_valid & ~redirect & ~pend_redir_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_ISSUE;
      pc_if_q       <= START_ADDR - 32'd4;
      inst_if_q     <= NOP_INST;
      inst_valid_q  <= 1'b0;
      fetch_fault_q <= 1'b0;
      pend_redir_q  <= 1'b0;
      redir_pc_q    <= 32'd0;
      req_pc_q      <= 32'd0;
    end else begin
      state_q       <= state_d;
      pc_if_q       <= pc_if_d;
      inst_if_q     <= inst_if_d;
      inst_valid_q  <= inst_valid_d;
      fetch_fault_q <= fetch_fault_d;
      pend_redir_q  <= pend_redir_d;
      redir_pc_q    <= redir_pc_d;
      req_pc_q      <= req_pc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_ISSUE: begin
        if (req_fire) state_d = S_WAIT;
        else          state_d = S_ISSUE;
      end
      S_WAIT: begin
        if (imem_resp_valid) state_d = S_ISSUE;
        else if (redirect)   state_d = S_DRAIN;
        else                 state_d = S_WAIT;
      end
      S_DRAIN: begin
        if (imem_resp_valid) state_d = S_ISSUE;
        else                 state_d = S_DRAIN;
      end
      default: state_d = S_ISSUE;
    endcase
  end

  // A redirect this cycle takes priority over an older latched target.
  always_comb begin
    imem_req_valid = 1'b0;
    if (redirect)          imem_addr = PC_PIF;
    else if (pend_redir_q) imem_addr = redir_pc_q;
    else                   imem_addr = PC_PIF;
    case (state_q)
      S_ISSUE: imem_req_valid = redirect | pend_redir_q | ~inst_valid_q | ~stall_IF;
      S_WAIT:  imem_req_valid = 1'b0;
      S_DRAIN: imem_req_valid = 1'b0;
      default: imem_req_valid = 1'b0;
    endcase
  end

  always_comb begin
    pc_if_d       = pc_if_q;
    inst_if_d     = inst_if_q;
    fetch_fault_d = fetch_fault_q;
    inst_valid_d  = inst_valid_q;
    redir_pc_d    = redir_pc_q;
    pend_redir_d  = pend_redir_q;
    req_pc_d      = req_pc_q;

    if (req_fire) req_pc_d = imem_addr;
    else          req_pc_d = req_pc_q;

    // The handshake consumes whichever target imem_addr presented, including a same-cycle redirect.
    if (redirect) redir_pc_d = PC_PIF;
    else          redir_pc_d = redir_pc_q;
    if (req_fire)      pend_redir_d = 1'b0;
    else if (redirect) pend_redir_d = 1'b1;
    else               pend_redir_d = pend_redir_q;

    if (resp_accept) begin
      pc_if_d       = req_pc_q;
      inst_if_d     = imem_resp_data;
      fetch_fault_d = imem_badmem_e;
      inst_valid_d  = 1'b1;
    end else if (redirect || (inst_valid_q && !stall_IF)) begin
      inst_valid_d  = 1'b0;
    end else begin
      inst_valid_d  = inst_valid_q;
    end
  end

  assign PC_IF         = pc_if_q;
  assign inst_IF       = inst_if_q;
  assign inst_valid_IF = inst_valid_q;
  assign fetch_fault   = fetch_fault_q;

endmodule

// File: tb/tb_vscale_fetch_unit.sv
// Directed per-cycle vectors for vscale_fetch_unit: each row drives one cycle of inputs
// and lists the outputs expected during that cycle.
module tb_vscale_fetch_unit;

  logic        clk;
  logic        reset;
  logic [31:0] PC_PIF;
  logic        redirect;
  logic        stall_IF;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        imem_badmem_e;
  logic [31:0] PC_IF;
  logic [31:0] inst_IF;
  logic        inst_valid_IF;
  logic        fetch_fault;

  int n_checks = 0;
  int n_fail   = 0;

  vscale_fetch_unit #(.START_ADDR(32'h0000_0200)) dut (
    .clk(clk), .reset(reset), .PC_PIF(PC_PIF), .redirect(redirect), .stall_IF(stall_IF),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .imem_badmem_e(imem_badmem_e), .PC_IF(PC_IF), .inst_IF(inst_IF),
    .inst_valid_IF(inst_valid_IF), .fetch_fault(fetch_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc_pif;
    logic        redir;
    logic        stall;
    logic        ready;
    logic        rvalid;
    logic [31:0] rdata;
    logic        bad;
    logic        e_req;
    logic [31:0] e_addr;
    logic [31:0] e_pc;
    logic [31:0] e_inst;
    logic        e_valid;
    logic        e_fault;
  } vec_t;

  vec_t vecs[$];

  task automatic v(input logic [31:0] pc_pif, input logic redir, input logic stall,
                   input logic ready, input logic rvalid, input logic [31:0] rdata,
                   input logic bad, input logic e_req, input logic [31:0] e_addr,
                   input logic [31:0] e_pc, input logic [31:0] e_inst,
                   input logic e_valid, input logic e_fault);
    vec_t r;
    r.pc_pif = pc_pif; r.redir = redir; r.stall = stall; r.ready = ready;
    r.rvalid = rvalid; r.rdata = rdata; r.bad = bad; r.e_req = e_req;
    r.e_addr = e_addr; r.e_pc = e_pc; r.e_inst = e_inst; r.e_valid = e_valid;
    r.e_fault = e_fault;
    vecs.push_back(r);
  endtask

  task automatic chk(input string name, input int row, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s row %0d: got 0x%08h expected 0x%08h", name, row, act, exp);
    end
  endtask

  task automatic drive(input vec_t r);
    PC_PIF = r.pc_pif; redirect = r.redir; stall_IF = r.stall; imem_req_ready = r.ready;
    imem_resp_valid = r.rvalid; imem_resp_data = r.rdata; imem_badmem_e = r.bad;
  endtask

  task automatic check_row(input vec_t r, input int row);
    chk("req_valid", row, {31'd0, imem_req_valid}, {31'd0, r.e_req});
    chk("imem_addr", row, imem_addr, r.e_addr);
    chk("PC_IF", row, PC_IF, r.e_pc);
    chk("inst_IF", row, inst_IF, r.e_inst);
    chk("inst_valid_IF", row, {31'd0, inst_valid_IF}, {31'd0, r.e_valid});
    chk("fetch_fault", row, {31'd0, fetch_fault}, {31'd0, r.e_fault});
  endtask

  initial begin
    vec_t r;
    // pc_pif redir stall ready rvalid rdata bad | req addr PC_IF inst valid fault
    // Reset, first fetch from 0x200 with a 1-cycle imem
    v(32'h200, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h200, 32'h1FC, 32'h13, 1'b0, 1'b0);
    v(32'h200, 1'b0, 1'b0, 1'b1, 1'b1, 32'hAAAA0001, 1'b0, 1'b0, 32'h200, 32'h1FC, 32'h13, 1'b0, 1'b0);
    // Decode stalls for 4 cycles with the instruction held
    for (int i = 0; i < 4; i++)
      v(32'h204, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h204, 32'h200, 32'hAAAA0001, 1'b1, 1'b0);
    v(32'h204, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h204, 32'h200, 32'hAAAA0001, 1'b1, 1'b0);
    // Faulting response at 0x204
    v(32'h204, 1'b0, 1'b0, 1'b1, 1'b1, 32'hBBBB0002, 1'b1, 1'b0, 32'h204, 32'h200, 32'hAAAA0001, 1'b0, 1'b0);
    v(32'h208, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h208, 32'h204, 32'hBBBB0002, 1'b1, 1'b1);
    // Redirect to 0x1000 while waiting; stale response arrives 3 cycles later
    v(32'h1000, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h1000, 32'h204, 32'hBBBB0002, 1'b0, 1'b1);
    v(32'h208, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h1000, 32'h204, 32'hBBBB0002, 1'b0, 1'b1);
    v(32'h208, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h1000, 32'h204, 32'hBBBB0002, 1'b0, 1'b1);
    v(32'h208, 1'b0, 1'b0, 1'b1, 1'b1, 32'hDEAD0000, 1'b0, 1'b0, 32'h1000, 32'h204, 32'hBBBB0002, 1'b0, 1'b1);
    v(32'h208, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h1000, 32'h204, 32'hBBBB0002, 1'b0, 1'b1);
    v(32'h208, 1'b0, 1'b0, 1'b1, 1'b1, 32'hCCCC0003, 1'b0, 1'b0, 32'h208, 32'h204, 32'hBBBB0002, 1'b0, 1'b1);
    v(32'h1004, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h1004, 32'h1000, 32'hCCCC0003, 1'b1, 1'b0);
    // Redirect to 0x80 in the same cycle as the response
    v(32'h80, 1'b1, 1'b0, 1'b1, 1'b1, 32'hDEAD0001, 1'b0, 1'b0, 32'h80, 32'h1000, 32'hCCCC0003, 1'b0, 1'b0);
    v(32'h1004, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h80, 32'h1000, 32'hCCCC0003, 1'b0, 1'b0);
    v(32'h1004, 1'b0, 1'b0, 1'b1, 1'b1, 32'hDDDD0004, 1'b0, 1'b0, 32'h1004, 32'h1000, 32'hCCCC0003, 1'b0, 1'b0);
    // imem not ready for 5 cycles, redirect to 0x40 on the second
    v(32'h84, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h84, 32'h80, 32'hDDDD0004, 1'b1, 1'b0);
    v(32'h40, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h40, 32'h80, 32'hDDDD0004, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++)
      v(32'h84, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h40, 32'h80, 32'hDDDD0004, 1'b0, 1'b0);
    v(32'h84, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h40, 32'h80, 32'hDDDD0004, 1'b0, 1'b0);
    v(32'h84, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h84, 32'h80, 32'hDDDD0004, 1'b0, 1'b0);
    v(32'h84, 1'b0, 1'b0, 1'b1, 1'b1, 32'hEEEE0005, 1'b0, 1'b0, 32'h84, 32'h80, 32'hDDDD0004, 1'b0, 1'b0);
    // Redirect kills a stalled instruction; PC_IF stays put
    v(32'h44, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h44, 32'h40, 32'hEEEE0005, 1'b1, 1'b0);
    v(32'h100, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h100, 32'h40, 32'hEEEE0005, 1'b1, 1'b0);
    v(32'h44, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h100, 32'h40, 32'hEEEE0005, 1'b0, 1'b0);
    v(32'h44, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h44, 32'h40, 32'hEEEE0005, 1'b0, 1'b0);

    r = vecs[0];
    drive(r);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i]);
      #1;
      check_row(vecs[i], i);
      @(negedge clk);
    end

    // The last row ended in WAIT; reset there must restart cleanly at 0x200
    reset = 1'b1;
    PC_PIF = 32'h44; redirect = 1'b0; stall_IF = 1'b0; imem_req_ready = 1'b1;
    imem_resp_valid = 1'b0; imem_resp_data = 32'h0; imem_badmem_e = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    PC_PIF = 32'h200;
    imem_req_ready = 1'b0;
    #1;
    chk("rst_req_valid", 100, {31'd0, imem_req_valid}, 32'd1);
    chk("rst_addr", 100, imem_addr, 32'h200);
    chk("rst_PC_IF", 100, PC_IF, 32'h1FC);
    chk("rst_inst_IF", 100, inst_IF, 32'h13);
    chk("rst_valid", 100, {31'd0, inst_valid_IF}, 32'd0);
    chk("rst_fault", 100, {31'd0, fetch_fault}, 32'd0);
    // A stray response while still in ISSUE must not load anything
    imem_resp_valid = 1'b1;
    imem_resp_data = 32'hBAD0BAD0;
    @(negedge clk);
    imem_resp_valid = 1'b0;
    #1;
    chk("rst_no_load_valid", 101, {31'd0, inst_valid_IF}, 32'd0);
    chk("rst_no_load_inst", 101, inst_IF, 32'h13);
    chk("rst_still_issue", 101, {31'd0, imem_req_valid}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
